mem_io_ctrl: RTL and testbench

Memory/IO bus controller between the CPU's memory port and the data RAM, LEDs and switches. Decodes each CPU access to RAM, the LED register, the switch input, or unmapped space. Sequences the synchronous-RAM read latency and signals completion with a one-cycle mem_ready pulse, so the CPU FSM waits on a handshake instead of counting fixed cycles.

---
 rtl/mem_io_pkg.sv | 31 +++
 rtl/mem_io_ctrl_sync2.sv | 26 ++
 rtl/mem_io_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_io_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared encodings for the memory/IO bus controller: command codes, FSM states,
// address-decode classes and default IO addresses.
package mem_io_pkg;

    localparam int MEM_ADDR_W = 9;
    localparam logic [MEM_ADDR_W-1:0] LED_ADDR_DEF = 9'h100;
    localparam logic [MEM_ADDR_W-1:0] SW_ADDR_DEF  = 9'h140;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10,
        MEM_RSVD  = 2'b11
    } mem_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RD_CAP  = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DEC_RAM      = 2'd0,
        DEC_LED      = 2'd1,
        DEC_SW       = 2'd2,
        DEC_UNMAPPED = 2'd3
    } dec_e;

endpackage

// File: rtl/mem_io_ctrl_sync2.sv
// Two-flop synchroniser for slow asynchronous inputs such as board switches.
module sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU memory-port controller: decodes accesses to data RAM, LED register and
// switches, sequences the synchronous-RAM latency and reports completion.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int                 ADDR_W   = MEM_ADDR_W,
    parameter int                 DATA_W   = 16,
    parameter int                 RAM_AW   = 8,
    parameter logic [ADDR_W-1:0]  LED_ADDR = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0]  SW_ADDR  = SW_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [7:0]        sw_in,
    output logic [7:0]        ledr_out,
    output state_e            dbg_state
);

    // Handshake: a command is taken only in IDLE at a rising edge; the CPU holds
    // mem_cmd/mem_addr/write_data until mem_ready, which is high for exactly the
    // RESP cycle, and must drop or replace mem_cmd during that cycle.

    state_e            state_q, state_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ledr_q, ledr_d;
    logic              mem_ready_q;
    logic              bus_err_q, bus_err_d;
    logic [7:0]        sw_sync;
    dec_e              dec;

    sync2 #(.W(8)) u_sw_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (sw_in),
        .q_o   (sw_sync)
    );

    always_comb begin
        dec = DEC_UNMAPPED;
        if (!mem_addr[ADDR_W-1]) begin
            dec = DEC_RAM;
        end else if (mem_addr == LED_ADDR) begin
            dec = DEC_LED;
        end else if (mem_addr == SW_ADDR) begin
            dec = DEC_SW;
        end
    end

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_we_d    = 1'b0;
        ledr_d      = ledr_q;
        bus_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                case (mem_cmd)
                    MEM_READ: begin
                        case (dec)
                            DEC_RAM: begin
                                ram_addr_d = mem_addr[RAM_AW-1:0];
                                state_d    = S_RD_WAIT;
                            end
                            DEC_SW: begin
                                read_data_d = {{(DATA_W-8){1'b0}}, sw_sync};
                                state_d     = S_RESP;
                            end
                            default: begin
                                // The LED register is write-only, so reads of it are unmapped.
                                read_data_d = '0;
                                bus_err_d   = 1'b1;
                                state_d     = S_RESP;
                            end
                        endcase
                    end
                    MEM_WRITE: begin
                        case (dec)
                            DEC_RAM: begin
                                ram_addr_d = mem_addr[RAM_AW-1:0];
                                ram_din_d  = write_data;
                                ram_we_d   = 1'b1;
                                state_d    = S_WR;
                            end
                            DEC_LED: begin
                                ledr_d  = write_data[7:0];
                                state_d = S_RESP;
                            end
                            default: begin
                                bus_err_d = 1'b1;
                                state_d   = S_RESP;
                            end
                        endcase
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_RD_WAIT: state_d = S_RD_CAP;
            S_RD_CAP: begin
                read_data_d = ram_dout;
                state_d     = S_RESP;
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            read_data_q <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_we_q    <= 1'b0;
            ledr_q      <= '0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_we_q    <= ram_we_d;
            ledr_q      <= ledr_d;
            mem_ready_q <= (state_d == S_RESP);
            bus_err_q   <= bus_err_d;
        end
    end

    assign read_data = read_data_q;
    assign mem_ready = mem_ready_q;
    assign bus_err   = bus_err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_we    = ram_we_q;
    assign ledr_out  = ledr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl with a behavioural synchronous RAM attached.
module tb_mem_io_ctrl;
    import mem_io_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        mem_ready;
    logic        bus_err;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [15:0] ram_dout;
    logic [7:0]  sw_in;
    logic [7:0]  ledr_out;
    state_e      dbg_state;

    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] tb_ram [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_io_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .mem_ready  (mem_ready),
        .bus_err    (bus_err),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .sw_in      (sw_in),
        .ledr_out   (ledr_out),
        .dbg_state  (dbg_state)
    );

    // Synchronous RAM: read data appears one clock after the address.
    always @(posedge clk) begin
        if (pre_en) tb_ram[pre_addr] <= pre_data;
        else if (ram_we) tb_ram[ram_addr] <= ram_din;
        ram_dout <= tb_ram[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (read_data !== 16'h0000) begin errors++; $display("FAIL reset_read_data got %h exp %h", read_data, 16'h0000); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", mem_ready); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b exp 0", bus_err); end
        checks++; if ({ram_we, ram_addr, ram_din} !== 25'h0) begin errors++; $display("FAIL reset_ram_if got %h exp 0", {ram_we, ram_addr, ram_din}); end
        checks++; if (ledr_out !== 8'h00) begin errors++; $display("FAIL reset_ledr got %h exp 00", ledr_out); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_ram_read();
        preload(8'h05, 16'hABCD);
        mem_addr = 9'h005; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_e0 got %b exp 0", mem_ready); end
        checks++; if (ram_addr !== 8'h05) begin errors++; $display("FAIL rd_ram_addr got %h exp 05", ram_addr); end
        tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_e1 got %b exp 0", mem_ready); end
        tick();
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL rd_ready_e2 got %b exp 1", mem_ready); end
        checks++; if (read_data !== 16'hABCD) begin errors++; $display("FAIL rd_data got %h exp abcd", read_data); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rd_bus_err got %b exp 0", bus_err); end
        tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_e3 got %b exp 0", mem_ready); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rd_state_e3 got %0d exp %0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_ram_write();
        preload(8'h06, 16'h0000);
        mem_addr = 9'h006; write_data = 16'hABCD; mem_cmd = MEM_WRITE;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if ({ram_we, ram_addr, ram_din} !== {1'b1, 8'h06, 16'hABCD}) begin errors++; $display("FAIL wr_ram_if_e0 got %h exp %h", {ram_we, ram_addr, ram_din}, {1'b1, 8'h06, 16'hABCD}); end
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_e0 got %b exp 0", mem_ready); end
        tick();
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL wr_we_e1 got %b exp 0", ram_we); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_e1 got %b exp 1", mem_ready); end
        checks++; if (read_data !== 16'hABCD) begin errors++; $display("FAIL wr_read_data_kept got %h exp abcd", read_data); end
        tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_e2 got %b exp 0", mem_ready); end
        checks++; if (tb_ram[6] !== 16'hABCD) begin errors++; $display("FAIL wr_ram_content got %h exp abcd", tb_ram[6]); end
        mem_addr = 9'h006; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        tick(); tick();
        checks++; if ({mem_ready, read_data} !== {1'b1, 16'hABCD}) begin errors++; $display("FAIL wr_readback got %h exp %h", {mem_ready, read_data}, {1'b1, 16'hABCD}); end
        tick();
    endtask

    task automatic test_led_write();
        preload(8'h00, 16'h1234);
        mem_addr = 9'h100; write_data = 16'h01A5; mem_cmd = MEM_WRITE;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if (ledr_out !== 8'hA5) begin errors++; $display("FAIL led_value got %h exp a5", ledr_out); end
        checks++; if ({mem_ready, bus_err, ram_we} !== 3'b100) begin errors++; $display("FAIL led_flags got %b exp 100", {mem_ready, bus_err, ram_we}); end
        tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL led_ready_end got %b exp 0", mem_ready); end
        checks++; if (read_data !== 16'hABCD) begin errors++; $display("FAIL led_read_data_kept got %h exp abcd", read_data); end
        mem_addr = 9'h000; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        tick(); tick();
        checks++; if (read_data !== 16'h1234) begin errors++; $display("FAIL led_ram_untouched got %h exp 1234", read_data); end
        tick();
    endtask

    task automatic test_sw_read();
        sw_in = 8'h3C;
        tick(); tick(); tick();
        mem_addr = 9'h140; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if ({mem_ready, read_data} !== {1'b1, 16'h003C}) begin errors++; $display("FAIL sw_read got %h exp %h", {mem_ready, read_data}, {1'b1, 16'h003C}); end
        tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL sw_ready_end got %b exp 0", mem_ready); end
        sw_in = 8'h55; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if (read_data !== 16'h003C) begin errors++; $display("FAIL sw_late_change got %h exp 003c", read_data); end
        tick(); tick();
        mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if (read_data !== 16'h0055) begin errors++; $display("FAIL sw_new_value got %h exp 0055", read_data); end
        tick();
    endtask

    task automatic test_unmapped();
        mem_addr = 9'h140; write_data = 16'h00FF; mem_cmd = MEM_WRITE;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if ({mem_ready, bus_err} !== 2'b11) begin errors++; $display("FAIL sw_write_err got %b exp 11", {mem_ready, bus_err}); end
        checks++; if ({ledr_out, read_data} !== {8'hA5, 16'h0055}) begin errors++; $display("FAIL sw_write_side_effect got %h exp %h", {ledr_out, read_data}, {8'hA5, 16'h0055}); end
        tick();
        mem_addr = 9'h180; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if ({mem_ready, bus_err, read_data} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL unmapped_read got %h exp %h", {mem_ready, bus_err, read_data}, {2'b11, 16'h0000}); end
        tick();
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unmapped_err_end got %b exp 0", bus_err); end
        mem_addr = 9'h100; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        checks++; if ({mem_ready, bus_err} !== 2'b11) begin errors++; $display("FAIL led_read_err got %b exp 11", {mem_ready, bus_err}); end
        tick();
        mem_addr = 9'h005; mem_cmd = MEM_RSVD;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({mem_ready, bus_err, dbg_state} !== {2'b00, S_IDLE}) begin errors++; $display("FAIL rsvd_cycle%0d got %h exp %h", i, {mem_ready, bus_err, dbg_state}, {2'b00, S_IDLE}); end
        end
        mem_cmd = MEM_NONE;
        tick();
    endtask

    task automatic test_back_to_back();
        mem_addr = 9'h140; mem_cmd = MEM_READ;
        tick();
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_first got %b exp 1", mem_ready); end
        tick();
        checks++; if ({mem_ready, dbg_state} !== {1'b0, S_IDLE}) begin errors++; $display("FAIL b2b_gap got %h exp %h", {mem_ready, dbg_state}, {1'b0, S_IDLE}); end
        tick();
        mem_cmd = MEM_NONE;
        checks++; if ({mem_ready, read_data} !== {1'b1, 16'h0055}) begin errors++; $display("FAIL b2b_second got %h exp %h", {mem_ready, read_data}, {1'b1, 16'h0055}); end
        tick();
    endtask

    task automatic test_reset_abort();
        mem_addr = 9'h005; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        tick();
        checks++; if (dbg_state !== S_RD_CAP) begin errors++; $display("FAIL abort_in_rd_cap got %0d exp %0d", dbg_state, S_RD_CAP); end
        reset_n = 1'b0;
        #1;
        checks++; if ({mem_ready, read_data, ram_we, ledr_out} !== 26'h0) begin errors++; $display("FAIL abort_outputs got %h exp 0", {mem_ready, read_data, ram_we, ledr_out}); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL abort_state got %0d exp %0d", dbg_state, S_IDLE); end
        tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL abort_no_pulse got %b exp 0", mem_ready); end
        reset_n = 1'b1;
        tick();
        mem_addr = 9'h005; mem_cmd = MEM_READ;
        tick();
        mem_cmd = MEM_NONE;
        tick();
        checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL fresh_ready_e1 got %b exp 0", mem_ready); end
        tick();
        checks++; if ({mem_ready, read_data} !== {1'b1, 16'hABCD}) begin errors++; $display("FAIL fresh_read got %h exp %h", {mem_ready, read_data}, {1'b1, 16'hABCD}); end
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        mem_cmd    = MEM_NONE;
        mem_addr   = '0;
        write_data = '0;
        sw_in      = '0;
        pre_en     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;
        tick(); tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_ram_read();
        test_ram_write();
        test_led_write();
        test_sw_read();
        test_unmapped();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
